// File: rtl/reg_bus_sequencer_pkg.sv
// Shared definitions for the register-bus sequencer.
//   state_t     : sequencer FSM state encoding (IDLE, DRIVE, LOAD, DONE)
//   BUS1, BUS2  : values of the bus-select field (0 = bus1, 1 = bus2)
//   clog2()     : ceiling log2, used to size register-select fields
package reg_bus_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic BUS1 = 1'b0;
  localparam logic BUS2 = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/reg_bus_sequencer_onehot_decoder.sv
// Index-to-one-hot decoder used for the load and output-enable strobes.
// Ports:
//   idx    : register index to select
//   en     : when low the output is all zero
//   onehot : NREGS-bit one-hot (or zero) strobe vector
// Indices outside 0..NREGS-1 decode to zero.
module onehot_decoder #(
  parameter int NREGS = 4,
  parameter int SELW  = 2
) (
  input  logic [SELW-1:0]  idx,
  input  logic             en,
  output logic [NREGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en && (int'(idx) < NREGS)) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/reg_bus_sequencer.sv
// Sequences register-to-register transfers over two shared tri-state buses:
// drive (settle) -> load -> turnaround, one request per handshake.
// Ports:
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   req_src, req_dst    : driving / loading register indices
//   req_bus             : 0 = bus1 (enable1), 1 = bus2 (enable2)
//   req_load            : 1 = move src->dst, 0 = drive-only
//   load                : per-register load strobes (one-hot or zero)
//   enable1, enable2    : per-register bus output enables (one-hot or zero)
//   bus_active          : bit0/bit1 = bus1/bus2 currently driven
//   done                : one-cycle pulse, transfer complete
//   err                 : one-cycle pulse, request rejected
// Strobes are decoded only from registered state and latched request fields.
module reg_bus_sequencer
  import reg_bus_sequencer_pkg::*;
#(
  parameter  int NREGS = 4,
  localparam int SELW  = clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SELW-1:0]  req_src,
  input  logic [SELW-1:0]  req_dst,
  input  logic             req_bus,
  input  logic             req_load,
  output logic [NREGS-1:0] load,
  output logic [NREGS-1:0] enable1,
  output logic [NREGS-1:0] enable2,
  output logic [1:0]       bus_active,
  output logic             done,
  output logic             err
);

  state_t          state, state_next;
  logic            err_q, err_next;
  logic [SELW-1:0] src_q, dst_q;
  logic            bus_q, load_q;
  logic            accept, illegal;
  logic            drive_on, load_on;

  always_comb begin
    illegal    = (req_load && (req_src == req_dst)) ||
                 (int'(req_src) >= NREGS) || (int'(req_dst) >= NREGS);
    accept     = (state == IDLE) && req_valid;
    state_next = state;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (illegal) err_next   = 1'b1;
          else         state_next = DRIVE;
        end
      end
      DRIVE:   state_next = load_q ? LOAD : DONE;
      LOAD:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      err_q <= err_next;
    end
  end

  // Request fields are plain data: latched on any IDLE edge with valid,
  // they are only consulted once the FSM has left IDLE.
  always_ff @(posedge clk) begin
    if (accept) begin
      src_q  <= req_src;
      dst_q  <= req_dst;
      bus_q  <= req_bus;
      load_q <= req_load;
    end
  end

  assign drive_on = (state == DRIVE) || (state == LOAD);
  // Gating with rst keeps the destination from capturing on an aborting edge.
  assign load_on  = (state == LOAD) && !rst;

  onehot_decoder #(.NREGS(NREGS), .SELW(SELW)) u_dec_load (
    .idx(dst_q), .en(load_on), .onehot(load)
  );

  onehot_decoder #(.NREGS(NREGS), .SELW(SELW)) u_dec_en1 (
    .idx(src_q), .en(drive_on && (bus_q == BUS1)), .onehot(enable1)
  );

  onehot_decoder #(.NREGS(NREGS), .SELW(SELW)) u_dec_en2 (
    .idx(src_q), .en(drive_on && (bus_q == BUS2)), .onehot(enable2)
  );

  assign bus_active = {|enable2, |enable1};
  assign done       = (state == DONE);
  assign err        = err_q;
  assign req_ready  = (state == IDLE) && !rst;

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Self-checking bench for reg_bus_sequencer (NREGS = 4).
// A reference model derives, per request, the expected cycle-by-cycle strobe
// timeline from the transfer rules, and a register array tracks expected
// register contents. A small register bank driven by the DUT strobes shows
// the data actually moved.
module tb_reg_bus_sequencer;

  localparam int NREGS = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_src = '0;
  logic [1:0]       req_dst = '0;
  logic             req_bus = 1'b0;
  logic             req_load = 1'b0;
  logic [NREGS-1:0] load, enable1, enable2;
  logic [1:0]       bus_active;
  logic             done, err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] bank [NREGS];
  logic [7:0] ref_regs [NREGS];
  logic [7:0] seed [NREGS];
  bit         seed_en = 1'b1;

  reg_bus_sequencer #(.NREGS(NREGS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst),
    .req_bus(req_bus), .req_load(req_load),
    .load(load), .enable1(enable1), .enable2(enable2),
    .bus_active(bus_active), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int oh_idx(input logic [NREGS-1:0] v);
    for (int i = 0; i < NREGS; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Register bank controlled by the DUT strobes.
  always @(posedge clk) begin
    if (seed_en) begin
      for (int i = 0; i < NREGS; i++) bank[i] <= seed[i];
    end else if (load != '0) begin
      bank[oh_idx(load)] <= (enable1 != '0) ? bank[oh_idx(enable1)]
                                            : bank[oh_idx(enable2)];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic invariants();
    check("onehot_en1", 32'($onehot0(enable1)), 32'd1);
    check("onehot_en2", 32'($onehot0(enable2)), 32'd1);
    check("onehot_load", 32'($onehot0(load)), 32'd1);
    check("no_contention", 32'((enable1 != '0) && (enable2 != '0)), 32'd0);
    check("done_err_excl", 32'(done && err), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    invariants();
  endtask

  task automatic idle_outputs(input string tag, input logic exp_ready);
    check({tag, "_en1"}, 32'(enable1), 32'd0);
    check({tag, "_en2"}, 32'(enable2), 32'd0);
    check({tag, "_load"}, 32'(load), 32'd0);
    check({tag, "_busact"}, 32'(bus_active), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'(exp_ready));
  endtask

  // Issue one request from IDLE and check the whole transfer timeline.
  task automatic do_req(input int src, input int dst, input int bus, input int ld,
                        input bit hold, output int acc_cyc);
    bit               legal;
    int               n;
    logic [NREGS-1:0] e_en, e_ld;
    req_src   = 2'(src);
    req_dst   = 2'(dst);
    req_bus   = 1'(bus);
    req_load  = 1'(ld);
    req_valid = 1'b1;
    check("ready_pre", 32'(req_ready), 32'd1);
    acc_cyc = cyc;
    tick();
    if (!hold) req_valid = 1'b0;
    legal = !((ld != 0) && (src == dst));
    // Cycles after acceptance: reject = 1, drive-only = 2, move = 3.
    n = !legal ? 1 : ((ld != 0) ? 3 : 2);
    for (int k = 1; k <= n; k++) begin
      e_en = (legal && k < n) ? NREGS'(1 << src) : '0;
      e_ld = (legal && ld != 0 && k == 2) ? NREGS'(1 << dst) : '0;
      check("en1", 32'(enable1), 32'((bus == 0) ? e_en : '0));
      check("en2", 32'(enable2), 32'((bus == 1) ? e_en : '0));
      check("load", 32'(load), 32'(e_ld));
      check("bus_active", 32'(bus_active),
            32'((e_en == '0) ? 2'b00 : ((bus == 0) ? 2'b01 : 2'b10)));
      check("done", 32'(done), 32'(legal && k == n));
      check("err", 32'(err), 32'(!legal));
      check("ready", 32'(req_ready), 32'(!legal));
      tick();
    end
    if (legal && ld != 0) ref_regs[dst] = ref_regs[src];
    check("reg_dst", 32'(bank[dst]), 32'(ref_regs[dst]));
    check("ready_post", 32'(req_ready), 32'd1);
    check("err_post", 32'(err), 32'd0);
  endtask

  initial begin
    int a0, a1, s, d;
    for (int i = 0; i < NREGS; i++) begin
      seed[i]     = 8'($urandom);
      ref_regs[i] = seed[i];
    end

    // Reset held two cycles with a request pending.
    rst = 1'b1; req_valid = 1'b1; req_src = 2'd1; req_dst = 2'd2; req_load = 1'b1;
    tick();
    idle_outputs("rst1", 1'b0);
    tick();
    idle_outputs("rst2", 1'b0);
    rst = 1'b0; req_valid = 1'b0; seed_en = 1'b0;
    #1;
    idle_outputs("post_rst", 1'b1);
    tick();
    idle_outputs("idle", 1'b1);

    // Move reg2 -> reg0 on bus1.
    do_req(2, 0, 0, 1, 1'b0, a0);
    check("move_eq", 32'(bank[0]), 32'(bank[2]));
    // Drive-only from reg3 on bus2.
    do_req(3, 0, 1, 0, 1'b0, a0);
    // Illegal src == dst move, then a legal follow-up.
    do_req(1, 1, 0, 1, 1'b0, a0);
    do_req(1, 2, 0, 1, 1'b0, a0);

    // Abort: reset during the LOAD cycle of reg0 -> reg3.
    req_src = 2'd0; req_dst = 2'd3; req_bus = 1'b0; req_load = 1'b1; req_valid = 1'b1;
    check("abort_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("abort_drive_en1", 32'(enable1), 32'h1);
    check("abort_drive_load", 32'(load), 32'd0);
    tick();
    check("abort_load_pre", 32'(load), 32'h8);
    rst = 1'b1;
    #1;
    check("abort_load_rst", 32'(load), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    idle_outputs("abort_after", 1'b1);
    tick();
    check("abort_no_done", 32'(done), 32'd0);
    check("abort_reg3", 32'(bank[3]), 32'(ref_regs[3]));

    // Back-to-back with valid held continuously.
    do_req(3, 1, 1, 1, 1'b1, a0);
    do_req(0, 2, 0, 1, 1'b0, a1);
    check("b2b_spacing", 32'(a1 - a0), 32'd4);

    // Randomized requests.
    for (int it = 0; it < 40; it++) begin
      s = int'($urandom_range(0, NREGS - 1));
      d = int'($urandom_range(0, NREGS - 1));
      do_req(s, d, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1'b0, a0);
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
        tick();
        idle_outputs("gap", 1'b1);
      end
    end

    for (int i = 0; i < NREGS; i++) check("final_reg", 32'(bank[i]), 32'(ref_regs[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_bus_sequencer.md
Name: reg_bus_sequencer

Overview:
- Control-side counterpart of the dual-output-enable register bank: generates the load/enable1/enable2 strobes that move data between registers over two shared tri-state buses.
- Accepts one transfer request per handshake and sequences drive -> load -> turnaround.
- Guarantees that no bus ever has two drivers.
- Sits between the datapath control FSM and a bank of NREGS dual-output registers.

Parameters:
- NREGS, 4, number of registers controlled (>=2)
- SELW, derived = clog2(NREGS), width of register select fields (localparam, not overridable)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  transfer request present
- req_ready  out  1  sequencer can accept a request (high only in IDLE)
- req_src  in  SELW  index of the register that drives the bus
- req_dst  in  SELW  index of the register to load from the bus
- req_bus  in  1  bus used: 0 = bus1 (enable1), 1 = bus2 (enable2)
- req_load  in  1  1 = move src->dst; 0 = drive-only (bus read by an external consumer)
- load  out  NREGS  per-register load strobes, one-hot or zero
- enable1  out  NREGS  per-register bus1 output enables, one-hot or zero
- enable2  out  NREGS  per-register bus2 output enables, one-hot or zero
- bus_active  out  2  bit0/bit1 = bus1/bus2 currently driven
- done  out  1  one-cycle pulse: transfer complete
- err  out  1  one-cycle pulse: request rejected

Behaviour:
- Reset: state=IDLE; load, enable1, enable2, bus_active, done, err = 0; req_ready = 1 in the cycle after reset deasserts. Reset mid-transfer aborts it on that edge with no load issued, and drops all enables.
- States: IDLE, DRIVE, LOAD, DONE.
- All outputs are registered or decoded from registered state and latched fields only; no combinational path from req_* to load/enable*.
- Acceptance: on an edge with IDLE && req_valid, latch src, dst, bus, and load.
  - Legal request -> DRIVE.
  - Illegal request (req_load=1 and src==dst, or any index >= NREGS) -> stay IDLE; err=1 for the next cycle; no strobes.
- DRIVE (1 cycle): enable{bus}[src]=1; all other enables 0; load=0. This is the settle cycle.
  - Next: LOAD if the latched load flag is 1, else DONE.
- LOAD (1 cycle): enable{bus}[src]=1 and load[dst]=1. The destination captures at the closing edge. Next: DONE.
- DONE (1 cycle): all enables and load are 0 (bus turnaround); done=1. Next: IDLE.
- Latency, accept edge at t:
  - move: DRIVE t+1, LOAD t+2, done at t+3, req_ready high at t+4.
  - drive-only: done at t+2, req_ready high at t+3.
- bus_active[b] = 1 exactly when any bit of enable{b} is 1.
- Invariants, checked every cycle:
  - at most one bit set in each of enable1, enable2, and load;
  - enable1 and enable2 never both nonzero;
  - load only in LOAD.
- req_valid outside IDLE is ignored; it is not queued. The requester holds valid until it sees ready.
- done and err are never high in the same cycle.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=0, DRIVE=1, LOAD=2, DONE=3);
  - the bus select constants BUS1=0, BUS2=1;
  - a clog2 helper function.
- One natural sub-module: onehot_decoder (SELW-bit index + enable in -> NREGS one-hot out). It is instantiated three times for load, enable1 and enable2.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req_valid=1 -> all strobes 0, req_ready=0 during reset and 1 the cycle after rst drops.
- Move: src=2, dst=0, bus=0, load=1, NREGS=4 -> enable1=4'b0100 for 2 cycles, load=4'b0001 in the 2nd of them, done pulse the next cycle, enable2 stays 0 throughout; a register model shows reg0 == reg2.
- Drive-only: src=3, bus=1, load=0 -> enable2=4'b1000 for exactly 1 cycle, load never asserted, done at t+2.
- Illegal request: src=dst=1 with load=1 -> err pulse 1 cycle, no strobes, req_ready stays 1. A following legal request (src=1, dst=2) is accepted normally.
- Abort: assert rst during the LOAD cycle of src=0->dst=3 -> load[3] is low on the reset edge, all enables 0 the next cycle, no done pulse.
- Back-to-back: two requests with req_valid held continuously -> second accepted 4 cycles after the first, at least one all-zero bus cycle between them; the one-hot/no-contention assertions pass across the whole run.
